uart_ctrl_fifo: RTL and testbench

Parametrised register-mapped controller that sits between the host bus and the existing `uart_brg`, `uart_trasmitter` and `uart_recevier` instances. It replaces combinational address decoding with clocked, write-strobed configuration registers. It adds a TX FIFO drained by a handshake state machine, an RX FIFO filled on `rx_done`, sticky overflow flags, flush controls and an interrupt output.

---
 rtl/uart_ctrl_fifo_if.sv | 13 +
 rtl/uart_ctrl_fifo.sv | 190 +++++++++++++++++++
 tb/tb_uart_ctrl_fifo.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_ctrl_fifo_if.sv
// Host register bus: single-cycle write/read strobes, shared address, registered read data.
interface uart_ctrl_fifo_if #(
    parameter int DATA_W = 8
);
    logic              wr_en;
    logic              rd_en;
    logic [2:0]        addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (output wr_en, rd_en, addr, wdata, input rdata);
    modport slave  (input wr_en, rd_en, addr, wdata, output rdata);
endinterface

// File: rtl/uart_ctrl_fifo.sv
// Register-mapped UART controller: clocked config registers, TX/RX FIFOs,
// a TX handshake FSM, sticky overflow flags and a registered interrupt.
module uart_ctrl_fifo #(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_ctrl_fifo_if.slave   bus,
    output logic              irq,
    output logic [1:0]        baud_rate,
    output logic [1:0]        parity_type,
    output logic [3:0]        frame_length,
    output logic              stop_bit_type,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_enable,
    input  logic              tx_done,
    output logic              rx_enable,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_done
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_CNT_FULL = TX_DEPTH[TX_AW:0];
    localparam logic [RX_AW:0] RX_CNT_FULL = RX_DEPTH[RX_AW:0];

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} tx_state_e;

    tx_state_e         state_q, state_d;
    logic [1:0]        baud_q, parity_q;
    logic [3:0]        flen_q;
    logic              stop_q;
    logic [3:0]        ctrl_q;          // {tx_irq_en, rx_irq_en, rx_en, tx_en}
    logic              tx_ovf_q, rx_ovf_q;
    logic [DATA_W-1:0] tx_data_q, rdata_q;
    logic              irq_q, rx_done_q;

    logic [DATA_W-1:0] tx_mem [TX_DEPTH];
    logic [DATA_W-1:0] rx_mem [RX_DEPTH];
    logic [TX_AW-1:0]  tx_wp_q, tx_rp_q;
    logic [TX_AW:0]    tx_cnt_q;
    logic [RX_AW-1:0]  rx_wp_q, rx_rp_q;
    logic [RX_AW:0]    rx_cnt_q;

    logic [7:0]        wdata8;
    logic              tx_busy, tx_empty, tx_full, rx_empty, rx_full;
    logic              tx_pop, tx_push_req, tx_push, tx_flush;
    logic              rx_pop, rx_push_req, rx_push, rx_flush;
    logic              cfg_wr, ctrl_wr, stat_wr, flen_ok;
    logic [6:0]        status;
    logic [DATA_W-1:0] rd_val;

    assign wdata8   = 8'(bus.wdata);
    assign tx_busy  = (state_q != S_IDLE);
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == TX_CNT_FULL);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == RX_CNT_FULL);
    assign status   = {rx_ovf_q, tx_ovf_q, rx_full, rx_empty, tx_full, tx_empty, tx_busy};

    // Config is frozen while a frame is in flight or the receiver is listening.
    assign cfg_wr   = bus.wr_en && !bus.addr[2] && !tx_busy && !ctrl_q[1];
    assign ctrl_wr  = bus.wr_en && (bus.addr == 3'd7);
    assign stat_wr  = bus.wr_en && (bus.addr == 3'd6);
    assign flen_ok  = (wdata8 >= 8'd5) && (wdata8 <= 8'(DATA_W));

    assign tx_push_req = bus.wr_en && (bus.addr == 3'd4);
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign tx_flush    = ctrl_wr && wdata8[4];
    assign rx_pop      = bus.rd_en && (bus.addr == 3'd5) && !rx_empty;
    assign rx_push_req = rx_done && !rx_done_q && ctrl_q[1];
    assign rx_push     = rx_push_req && (!rx_full || rx_pop);
    assign rx_flush    = ctrl_wr && wdata8[5];

    always_comb begin
        state_d = state_q;
        tx_pop  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ctrl_q[0] && !tx_empty && !tx_done) begin
                    tx_pop  = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND:  if (tx_done) state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        case (bus.addr)
            3'd0: rd_val = DATA_W'(baud_q);
            3'd1: rd_val = DATA_W'(parity_q);
            3'd2: rd_val = DATA_W'(flen_q);
            3'd3: rd_val = DATA_W'(stop_q);
            3'd4: rd_val = '0;
            3'd5: if (!rx_empty) rd_val = rx_mem[rx_rp_q];
            3'd6: rd_val = DATA_W'(status);
            default: rd_val = DATA_W'(ctrl_q);
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= bus.wdata;
        if (rx_push) rx_mem[rx_wp_q] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (tx_flush) begin
                tx_wp_q  <= '0;
                tx_rp_q  <= '0;
                tx_cnt_q <= '0;
            end else begin
                if (tx_push) tx_wp_q <= tx_wp_q + TX_AW'(1);
                if (tx_pop)  tx_rp_q <= tx_rp_q + TX_AW'(1);
                if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + (TX_AW+1)'(1);
                else if (tx_pop && !tx_push) tx_cnt_q <= tx_cnt_q - (TX_AW+1)'(1);
            end
            if (rx_flush) begin
                rx_wp_q  <= '0;
                rx_rp_q  <= '0;
                rx_cnt_q <= '0;
            end else begin
                if (rx_push) rx_wp_q <= rx_wp_q + RX_AW'(1);
                if (rx_pop)  rx_rp_q <= rx_rp_q + RX_AW'(1);
                if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + (RX_AW+1)'(1);
                else if (rx_pop && !rx_push) rx_cnt_q <= rx_cnt_q - (RX_AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            baud_q    <= 2'b11;
            parity_q  <= 2'b01;
            flen_q    <= 4'd5;
            stop_q    <= 1'b0;
            ctrl_q    <= '0;
            tx_ovf_q  <= 1'b0;
            rx_ovf_q  <= 1'b0;
            tx_data_q <= '0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
            rx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_done_q <= rx_done;
            irq_q     <= (ctrl_q[2] && !rx_empty) || (ctrl_q[3] && tx_empty && !tx_busy)
                         || tx_ovf_q || rx_ovf_q;
            if (tx_pop)    tx_data_q <= tx_mem[tx_rp_q];
            if (bus.rd_en) rdata_q   <= rd_val;
            if (cfg_wr) begin
                case (bus.addr)
                    3'd0:    baud_q   <= wdata8[1:0];
                    3'd1:    parity_q <= wdata8[1:0];
                    3'd2:    if (flen_ok) flen_q <= wdata8[3:0];
                    default: stop_q   <= wdata8[0];
                endcase
            end
            if (ctrl_wr) ctrl_q <= wdata8[3:0];
            // A new overflow in the same cycle as a clear wins, so no event is lost.
            if (stat_wr && wdata8[5]) tx_ovf_q <= 1'b0;
            if (stat_wr && wdata8[6]) rx_ovf_q <= 1'b0;
            if (tx_push_req && !tx_push) tx_ovf_q <= 1'b1;
            if (rx_push_req && !rx_push) rx_ovf_q <= 1'b1;
        end
    end

    assign bus.rdata     = rdata_q;
    assign irq           = irq_q;
    assign baud_rate     = baud_q;
    assign parity_type   = parity_q;
    assign frame_length  = flen_q;
    assign stop_bit_type = stop_q;
    assign tx_data       = tx_data_q;
    assign tx_enable     = (state_q == S_SEND);
    assign rx_enable     = ctrl_q[1];
endmodule

// File: tb/tb_uart_ctrl_fifo.sv
// Bench for uart_ctrl_fifo: queue-based reference model checked every cycle,
// directed register/FIFO scenarios, then randomized bus and receiver traffic.
module tb_uart_ctrl_fifo;
    localparam int DATA_W   = 8;
    localparam int TX_DEPTH = 8;
    localparam int RX_DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tx_done = 1'b0;
    logic              rx_done = 1'b0;
    logic [DATA_W-1:0] rx_data = '0;
    logic              irq, stop_bit_type, tx_enable, rx_enable;
    logic [1:0]        baud_rate, parity_type;
    logic [3:0]        frame_length;
    logic [DATA_W-1:0] tx_data;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    uart_ctrl_fifo_if #(.DATA_W(DATA_W)) bus ();

    uart_ctrl_fifo #(.DATA_W(DATA_W), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .irq(irq),
        .baud_rate(baud_rate), .parity_type(parity_type), .frame_length(frame_length),
        .stop_bit_type(stop_bit_type), .tx_data(tx_data), .tx_enable(tx_enable),
        .tx_done(tx_done), .rx_enable(rx_enable), .rx_data(rx_data), .rx_done(rx_done)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [1:0] m_baud = 2'b11, m_par = 2'b01;
    logic [3:0] m_flen = 4'd5, m_ctrl = 4'd0;
    logic       m_stop = 1'b0, m_tx_ovf = 1'b0, m_rx_ovf = 1'b0;
    logic       m_sending = 1'b0, m_gap = 1'b0, m_rx_prev = 1'b0, m_irq = 1'b0;
    logic [7:0] m_tx_data = 8'h00, m_rdata = 8'h00;
    logic       mb_busy, mb_pop, mb_w, mb_r;
    logic [7:0] mb_d;
    logic [2:0] mb_a;

    function automatic logic [7:0] model_read(input logic [2:0] a, input logic busy);
        case (a)
            3'd0: return {6'd0, m_baud};
            3'd1: return {6'd0, m_par};
            3'd2: return {4'd0, m_flen};
            3'd3: return {7'd0, m_stop};
            3'd4: return 8'h00;
            3'd5: return (rx_q.size() != 0) ? rx_q[0] : 8'h00;
            3'd6: return {1'b0, m_rx_ovf, m_tx_ovf, rx_q.size() == RX_DEPTH, rx_q.size() == 0,
                          tx_q.size() == TX_DEPTH, tx_q.size() == 0, busy};
            default: return {4'd0, m_ctrl};
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q.delete(); rx_q.delete();
            m_baud = 2'b11; m_par = 2'b01; m_flen = 4'd5; m_stop = 1'b0; m_ctrl = 4'd0;
            m_tx_ovf = 1'b0; m_rx_ovf = 1'b0; m_sending = 1'b0; m_gap = 1'b0;
            m_rx_prev = 1'b0; m_irq = 1'b0; m_tx_data = 8'h00; m_rdata = 8'h00;
        end else begin
            mb_w = bus.wr_en; mb_r = bus.rd_en; mb_a = bus.addr; mb_d = bus.wdata;
            mb_busy = m_sending || m_gap;
            mb_pop  = !mb_busy && m_ctrl[0] && (tx_q.size() != 0) && !tx_done;
            m_irq = (m_ctrl[2] && rx_q.size() != 0) || (m_ctrl[3] && tx_q.size() == 0 && !mb_busy)
                    || m_tx_ovf || m_rx_ovf;
            if (mb_r) m_rdata = model_read(mb_a, mb_busy);
            if (m_sending) begin
                if (tx_done) begin m_sending = 1'b0; m_gap = 1'b1; end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (mb_pop) begin
                m_sending = 1'b1;
                m_tx_data = tx_q.pop_front();
            end
            if (mb_w && mb_a == 3'd6) begin
                if (mb_d[5]) m_tx_ovf = 1'b0;
                if (mb_d[6]) m_rx_ovf = 1'b0;
            end
            if (mb_w && mb_a == 3'd4) begin
                if (tx_q.size() < TX_DEPTH) tx_q.push_back(mb_d);
                else m_tx_ovf = 1'b1;
            end
            if (mb_r && mb_a == 3'd5 && rx_q.size() != 0) void'(rx_q.pop_front());
            if (rx_done && !m_rx_prev && m_ctrl[1]) begin
                if (rx_q.size() < RX_DEPTH) rx_q.push_back(rx_data);
                else m_rx_ovf = 1'b1;
            end
            m_rx_prev = rx_done;
            if (mb_w && mb_a < 3'd4 && !mb_busy && !m_ctrl[1]) begin
                case (mb_a)
                    3'd0: m_baud = mb_d[1:0];
                    3'd1: m_par  = mb_d[1:0];
                    3'd2: if (mb_d >= 8'd5 && mb_d <= DATA_W) m_flen = mb_d[3:0];
                    default: m_stop = mb_d[0];
                endcase
            end
            if (mb_w && mb_a == 3'd7) begin
                m_ctrl = mb_d[3:0];
                if (mb_d[4]) tx_q.delete();
                if (mb_d[5]) rx_q.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            cmp("rdata", bus.rdata, m_rdata);
            cmp("irq", irq, m_irq);
            cmp("tx_enable", tx_enable, m_sending);
            cmp("tx_data", tx_data, m_tx_data);
            cmp("rx_enable", rx_enable, m_ctrl[1]);
            cmp("config", {baud_rate, parity_type, frame_length, stop_bit_type},
                {m_baud, m_par, m_flen, m_stop});
        end
    end

    // ---------------- transmitter stand-in ----------------
    int en_cnt = 0, hold_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            tx_done = 1'b0; en_cnt = 0; hold_cnt = 0;
        end else if (hold_cnt > 0) begin
            hold_cnt--;
            if (hold_cnt == 0) tx_done = 1'b0;
        end else if (tx_enable) begin
            en_cnt++;
            if (en_cnt == 10) begin tx_done = 1'b1; hold_cnt = 2; en_cnt = 0; end
        end
    end

    // Frame observer: tx_data at each tx_enable rise and the shortest low gap between frames.
    logic [7:0] frames[$];
    int   gap_min = 1000, low_run = 0;
    logic prev_en = 1'b0;
    always @(negedge clk) begin
        if (tx_enable && !prev_en) begin
            frames.push_back(tx_data);
            if (frames.size() > 1 && low_run < gap_min) gap_min = low_run;
        end
        if (!tx_enable) low_run++; else low_run = 0;
        prev_en = tx_enable;
    end

    // ---------------- bus tasks (entered on a negedge) ----------------
    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        bus.wr_en = 1'b1; bus.addr = a; bus.wdata = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
        $display("write addr=%0d data=0x%02h", a, d);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        bus.rd_en = 1'b1; bus.addr = a;
        @(negedge clk);
        bus.rd_en = 1'b0;
        d = bus.rdata;
        $display("read  addr=%0d data=0x%02h", a, d);
    endtask

    task automatic read_chk(input string name, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] v;
        bus_read(a, v);
        cmp(name, v, exp);
    endtask

    task automatic rx_pulse(input logic [7:0] v);
        rx_data = v; rx_done = 1'b1;
        repeat (2) @(negedge clk);
        rx_done = 1'b0;
        repeat (2) @(negedge clk);
        $display("rx frame 0x%02h", v);
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = 3'd0; bus.wdata = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cmp_on = 1'b1;
        @(negedge clk);

        // Reset values
        read_chk("rst_baud", 3'd0, 8'h03);
        read_chk("rst_parity", 3'd1, 8'h01);
        read_chk("rst_flen", 3'd2, 8'h05);
        read_chk("rst_stop", 3'd3, 8'h00);
        read_chk("rst_status", 3'd6, 8'h0A);

        // Two back-to-back frames
        frames.delete(); gap_min = 1000;
        bus_write(3'd7, 8'h01);
        bus_write(3'd4, 8'hA5);
        bus_write(3'd4, 8'h3C);
        for (int k = 0; k < 200 && !(frames.size() == 2 && !tx_enable); k++) @(negedge clk);
        repeat (4) @(negedge clk);
        cmp("frame_count", frames.size(), 2);
        if (frames.size() == 2) begin
            cmp("frame0", frames[0], 8'hA5);
            cmp("frame1", frames[1], 8'h3C);
        end
        cmp("gap_at_least_1", gap_min >= 1, 1'b1);
        read_chk("tx_done_status", 3'd6, 8'h0A);

        // TX overflow, sticky clear, flush
        bus_write(3'd7, 8'h00);
        for (int k = 0; k <= TX_DEPTH; k++) bus_write(3'd4, 8'(k + 8'h40));
        read_chk("tx_full_ovf", 3'd6, 8'h2C);
        cmp("irq_on_ovf", irq, 1'b1);
        bus_write(3'd6, 8'h20);
        read_chk("tx_ovf_cleared", 3'd6, 8'h0C);
        bus_write(3'd7, 8'h10);
        read_chk("tx_flushed", 3'd6, 8'h0A);

        // RX path and interrupt
        bus_write(3'd7, 8'h06);
        rx_pulse(8'h11); rx_pulse(8'h22); rx_pulse(8'h33);
        cmp("irq_rx", irq, 1'b1);
        read_chk("rx0", 3'd5, 8'h11);
        read_chk("rx1", 3'd5, 8'h22);
        read_chk("rx2", 3'd5, 8'h33);
        read_chk("rx_empty_read", 3'd5, 8'h00);
        cmp("irq_rx_clear", irq, 1'b0);
        read_chk("rx_status", 3'd6, 8'h0A);

        // Configuration lock and frame_length range
        bus_write(3'd7, 8'h02);
        bus_write(3'd2, 8'h07);
        read_chk("flen_locked", 3'd2, 8'h05);
        bus_write(3'd7, 8'h00);
        bus_write(3'd2, 8'h09);
        read_chk("flen_range", 3'd2, 8'h05);
        bus_write(3'd2, 8'h08);
        read_chk("flen_8", 3'd2, 8'h08);

        // Asynchronous reset in the middle of a frame
        bus_write(3'd7, 8'h01);
        bus_write(3'd4, 8'h5A);
        for (int k = 0; k < 20 && !tx_enable; k++) @(negedge clk);
        cmp("mid_frame_setup", tx_enable, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        cmp("async_tx_enable", tx_enable, 1'b0);
        cmp("async_tx_data", tx_data, 8'h00);
        cmp("async_flen", frame_length, 4'd5);
        cmp("async_rdata", bus.rdata, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_chk("post_baud", 3'd0, 8'h03);
        read_chk("post_parity", 3'd1, 8'h01);
        read_chk("post_flen", 3'd2, 8'h05);
        read_chk("post_stop", 3'd3, 8'h00);
        read_chk("post_status", 3'd6, 8'h0A);
        read_chk("post_ctrl", 3'd7, 8'h00);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            int op;
            op = $urandom_range(0, 9);
            bus.wr_en = 1'b0; bus.rd_en = 1'b0;
            bus.addr  = 3'($urandom_range(0, 7));
            bus.wdata = 8'($urandom);
            if (op < 2) bus.addr = 3'd4;
            if (bus.addr == 3'd7 && $urandom_range(0, 3) != 0) bus.wdata[5:4] = 2'b00;
            if (bus.addr == 3'd2) bus.wdata = 8'($urandom_range(3, 10));
            if (op < 5) bus.wr_en = 1'b1;
            else if (op < 8) bus.rd_en = 1'b1;
            else if (op == 8) begin bus.wr_en = 1'b1; bus.rd_en = 1'b1; end
            if ($urandom_range(0, 3) == 0) rx_done = ~rx_done;
            rx_data = 8'($urandom);
            @(negedge clk);
            if (i % 100 == 0) $display("random step %0d txq=%0d rxq=%0d", i, tx_q.size(), rx_q.size());
        end
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
